fifo_rd_stream: RTL and testbench



---
 rtl/fifo_rd_stream_pkg.sv | 7 +
 rtl/fifo_rd_stream_skid_buf2.sv | 31 +++
 rtl/fifo_rd_stream.sv | 43 ++++
 tb/tb_fifo_rd_stream.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// fifo_pkg: shared constants and helpers for the FIFO and its read stream stage
package fifo_pkg;
  localparam int SKID_DEPTH = 2;
  function automatic int cnt_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/fifo_rd_stream_skid_buf2.sv
// skid_buf2: two-entry ring buffer with push at tail, pop at head, occupancy count
module skid_buf2 import fifo_pkg::*; #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       cnt,
  output logic [WIDTH-1:0] head_data
);
  logic [WIDTH-1:0] mem [SKID_DEPTH];
  logic head, tail;
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      mem  <= '{default: '0};
      head <= 1'b0;
      tail <= 1'b0;
      cnt  <= 2'd0;
    end else begin
      if (push) mem[tail] <= push_data;
      tail <= tail ^ push;
      head <= head ^ pop;
      cnt  <= cnt + 2'(push) - 2'(pop);
    end
  end
  assign head_data = (cnt != 2'd0) ? mem[head] : '0;
  a_no_overflow: assert property (@(posedge clk_i) disable iff (srst_i) !(push && cnt == 2'd2));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (srst_i) !(pop && cnt == 2'd0));
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: turns the FIFO registered read port into a valid/ready packet stream
module fifo_rd_stream import fifo_pkg::*; #(
  parameter int WIDTH   = 4,
  parameter int PKT_LEN = 4
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] fifo_rd_data_i,
  input  logic             fifo_empty_i,
  output logic             fifo_rd_req_o,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             last_o
);
  localparam int CNT_W = cnt_w(PKT_LEN);
  logic             inflight, pop;
  logic [1:0]       buf_cnt, occ;
  logic [CNT_W-1:0] cnt;
  assign pop           = valid_o && ready_i;
  assign occ           = buf_cnt + 2'(inflight);
  assign fifo_rd_req_o = !srst_i && !fifo_empty_i && (occ - 2'(pop) < 2'd2);
  assign valid_o       = buf_cnt != 2'd0;
  assign last_o        = valid_o && (cnt == CNT_W'(PKT_LEN - 1));
  skid_buf2 #(.WIDTH(WIDTH)) u_buf (
    .clk_i     (clk_i),
    .srst_i    (srst_i),
    .push      (inflight),
    .push_data (fifo_rd_data_i),
    .pop       (pop),
    .cnt       (buf_cnt),
    .head_data (data_o)
  );
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      inflight <= 1'b0;
      cnt      <= '0;
    end else begin
      inflight <= fifo_rd_req_o;
      if (pop) cnt <= (cnt == CNT_W'(PKT_LEN - 1)) ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed checks of the FIFO read stream stage against a behavioural FIFO
module tb_fifo_rd_stream;
  logic       clk_i = 1'b0, srst_i = 1'b1, ready_i = 1'b0;
  logic       fifo_empty_i, fifo_rd_req_o, valid_o, last_o;
  logic [3:0] fifo_rd_data_i = '0, data_o;
  logic [3:0] fmem [256];
  int         wp = 0, rp = 0, checks = 0, failures = 0, reads = 0, cyc = 0;
  logic [3:0] obs_d [$];
  logic       obs_l [$];
  int         obs_t [$];
  logic [3:0] exp_q [$];
  logic       pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [3:0] pd = '0;
  logic [3:0] d;
  always #5 clk_i = ~clk_i;
  assign fifo_empty_i = (wp == rp);
  fifo_rd_stream #(.WIDTH(4), .PKT_LEN(4)) dut (
    .clk_i          (clk_i),
    .srst_i         (srst_i),
    .fifo_rd_data_i (fifo_rd_data_i),
    .fifo_empty_i   (fifo_empty_i),
    .fifo_rd_req_o  (fifo_rd_req_o),
    .data_o         (data_o),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .last_o         (last_o)
  );
  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (fifo_rd_req_o && wp != rp) begin
      fifo_rd_data_i <= fmem[rp[7:0]];
      rp <= rp + 1;
    end
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk_i) begin
    if (!srst_i && pv && !pr) begin
      check("hold_valid", 32'(valid_o), 1);
      check("hold_data", 32'(data_o), 32'(pd));
      check("hold_last", 32'(last_o), 32'(pl));
    end
    if (!srst_i && valid_o && ready_i) begin
      obs_d.push_back(data_o);
      obs_l.push_back(last_o);
      obs_t.push_back(cyc);
    end
    if (!srst_i && fifo_rd_req_o) reads++;
    pv = valid_o && !srst_i;
    pr = ready_i;
    pd = data_o;
    pl = last_o;
  end
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  task automatic push(input logic [3:0] v);
    fmem[wp[7:0]] = v;
    wp++;
  endtask
  task automatic reset_hold;
    srst_i = 1'b1;
    ready_i = 1'b0;
    tick;
    tick;
    wp = rp;
    obs_d.delete();
    obs_l.delete();
    obs_t.delete();
    exp_q.delete();
    reads = 0;
  endtask
  task automatic wait_beats(input int n, input int budget);
    int k = 0;
    while (obs_d.size() < n && k < budget) begin
      tick;
      k++;
    end
    repeat (4) tick;
    check("beat_count", 32'(obs_d.size()), 32'(n));
  endtask
  task automatic check_seq;
    for (int i = 0; i < exp_q.size(); i++)
      if (i < obs_d.size()) begin
        check("seq_data", 32'(obs_d[i]), 32'(exp_q[i]));
        check("seq_last", 32'(obs_l[i]), 32'(i % 4 == 3));
      end
  endtask
  initial begin
    srst_i = 1'b1;
    ready_i = 1'b0;
    push(4'h1); push(4'h2); push(4'h3);
    exp_q = '{4'h1, 4'h2, 4'h3};
    repeat (3) begin
      tick;
      check("rst_valid", 32'(valid_o), 0);
      check("rst_data", 32'(data_o), 0);
      check("rst_last", 32'(last_o), 0);
      check("rst_req", 32'(fifo_rd_req_o), 0);
    end
    srst_i = 1'b0;
    #1;
    check("rel_req", 32'(fifo_rd_req_o), 1);
    check("rel_valid0", 32'(valid_o), 0);
    tick;
    check("rel_valid1", 32'(valid_o), 0);
    tick;
    check("rel_valid2", 32'(valid_o), 1);
    check("rel_data2", 32'(data_o), 1);
    ready_i = 1'b1;
    wait_beats(3, 20);
    check_seq;

    reset_hold;
    for (int i = 0; i < 8; i++) begin
      push(4'(i));
      exp_q.push_back(4'(i));
    end
    ready_i = 1'b1;
    srst_i = 1'b0;
    wait_beats(8, 30);
    check_seq;
    for (int i = 1; i < 8; i++)
      if (i < obs_t.size()) check("no_gap", 32'(obs_t[i] - obs_t[0]), 32'(i));

    reset_hold;
    for (int i = 0; i < 4; i++) begin
      push(4'(i));
      exp_q.push_back(4'(i));
    end
    srst_i = 1'b0;
    repeat (6) tick;
    check("bp_reads", 32'(reads), 2);
    check("bp_valid", 32'(valid_o), 1);
    check("bp_data", 32'(data_o), 0);
    check("bp_last", 32'(last_o), 0);
    check("bp_req", 32'(fifo_rd_req_o), 0);
    ready_i = 1'b1;
    wait_beats(4, 20);
    check_seq;

    reset_hold;
    srst_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      ready_i = ~ready_i;
      if ($urandom_range(0, 1) == 1) begin
        d = 4'($urandom);
        push(d);
        exp_q.push_back(d);
      end
      tick;
    end
    begin
      int k = 0;
      while (obs_d.size() < exp_q.size() && k < 100) begin
        ready_i = ~ready_i;
        tick;
        k++;
      end
    end
    ready_i = 1'b1;
    repeat (4) tick;
    check("tog_count", 32'(obs_d.size()), 32'(exp_q.size()));
    check_seq;

    reset_hold;
    ready_i = 1'b1;
    srst_i = 1'b0;
    repeat (3) begin
      tick;
      check("empty_req", 32'(fifo_rd_req_o), 0);
      check("empty_valid", 32'(valid_o), 0);
    end
    push(4'hA);
    exp_q.push_back(4'hA);
    #1;
    check("one_req", 32'(fifo_rd_req_o), 1);
    tick;
    tick;
    check("one_valid", 32'(valid_o), 1);
    check("one_data", 32'(data_o), 32'hA);
    tick;
    check("one_drop", 32'(valid_o), 0);
    repeat (3) begin
      tick;
      check("after_req", 32'(fifo_rd_req_o), 0);
      check("after_valid", 32'(valid_o), 0);
    end
    check("one_count", 32'(obs_d.size()), 1);
    check_seq;

    reset_hold;
    ready_i = 1'b1;
    srst_i = 1'b0;
    push(4'h1);
    push(4'h2);
    repeat (5) tick;
    check("pre_count", 32'(obs_d.size()), 2);
    ready_i = 1'b0;
    push(4'h5);
    #1;
    check("fly_req", 32'(fifo_rd_req_o), 1);
    tick;
    srst_i = 1'b1;
    #1;
    check("fly_req_forced", 32'(fifo_rd_req_o), 0);
    tick;
    srst_i = 1'b0;
    wp = rp;
    #1;
    check("fly_valid", 32'(valid_o), 0);
    check("fly_data", 32'(data_o), 0);
    tick;
    check("fly_valid_next", 32'(valid_o), 0);
    obs_d.delete();
    obs_l.delete();
    obs_t.delete();
    exp_q.delete();
    for (int i = 8; i < 12; i++) begin
      push(4'(i));
      exp_q.push_back(4'(i));
    end
    ready_i = 1'b1;
    wait_beats(4, 20);
    check_seq;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
